// File: rtl/food_placer.sv
// Picks a free cell for new food: starts at a pseudorandom index and walks the
// occupancy RAM linearly (with wrap-around) until a free cell or a full grid is found.
//
// state  | meaning
// IDLE   | waiting for a request; done/full pulse here for one cycle
// LOOKUP | occ_addr presents cand to the RAM
// CHECK  | occ_data holds the occupancy of cand; place food, report full or advance
module food_placer #(
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              request,
   input  logic [ADDR_W-1:0] grid_max,
   output logic [ADDR_W-1:0] rand_max,
   input  logic [ADDR_W-1:0] rand_in,
   output logic [ADDR_W-1:0] occ_addr,
   input  logic              occ_data,
   output logic [ADDR_W-1:0] food_pos,
   output logic              done,
   output logic              full,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      CHECK  = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] gmax_q;
   logic [ADDR_W-1:0] cand;
   logic [ADDR_W-1:0] probe_q;
   logic [ADDR_W-1:0] first_cand;
   logic [ADDR_W-1:0] next_cand;

   assign rand_max   = grid_max;
   assign busy       = (state != IDLE);
   // An out-of-range random value restarts the walk from cell 0.
   assign first_cand = (rand_in > grid_max) ? '0 : rand_in;
   assign next_cand  = (cand == gmax_q) ? '0 : cand + ADDR_W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         gmax_q   <= '0;
         cand     <= '0;
         probe_q  <= '0;
         occ_addr <= '0;
         food_pos <= '0;
         done     <= 1'b0;
         full     <= 1'b0;
      end else begin
         done <= 1'b0;
         full <= 1'b0;
         case (state)
            IDLE: begin
               // A request coinciding with the done/full pulse is dropped.
               if (request && !done && !full) begin
                  gmax_q   <= grid_max;
                  cand     <= first_cand;
                  occ_addr <= first_cand;
                  probe_q  <= '0;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: state <= CHECK;
            CHECK: begin
               if (!occ_data) begin
                  food_pos <= cand;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else if (probe_q == gmax_q) begin
                  full  <= 1'b1;
                  state <= IDLE;
               end else begin
                  cand     <= next_cand;
                  occ_addr <= next_cand;
                  probe_q  <= probe_q + ADDR_W'(1);
                  state    <= LOOKUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed scenarios plus randomized grids checked
// against a simple first-free-cell search over a behavioural occupancy array.
module tb_food_placer;
   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          reset;
   logic          request;
   logic [AW-1:0] grid_max;
   logic [AW-1:0] rand_max;
   logic [AW-1:0] rand_in;
   logic [AW-1:0] occ_addr;
   logic          occ_data;
   logic [AW-1:0] food_pos;
   logic          done;
   logic          full;
   logic          busy;

   bit mem [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_bad = 0;

   int obs_cycle;
   bit obs_done, obs_full, obs_both, obs_b1, obs_b2;
   int obs_addr [$];

   food_placer #(.ADDR_W(AW)) dut (
      .clock   (clock),
      .reset   (reset),
      .request (request),
      .grid_max(grid_max),
      .rand_max(rand_max),
      .rand_in (rand_in),
      .occ_addr(occ_addr),
      .occ_data(occ_data),
      .food_pos(food_pos),
      .done    (done),
      .full    (full),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   // synchronous-read occupancy RAM
   always @(posedge clock) occ_data <= mem[occ_addr];

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 1'b0;
   endtask

   // Called at a negedge (cycle 0); pulses request and watches until done/full.
   task automatic do_request(input int start, input int gmax, input bit mid_req, input int mid_gmax);
      int budget;
      budget = 2 * (gmax + 1) + 8;
      request  = 1'b1;
      rand_in  = AW'(start);
      grid_max = AW'(gmax);
      obs_addr.delete();
      obs_cycle = -1;
      obs_done = 0; obs_full = 0; obs_both = 0; obs_b1 = 0; obs_b2 = 0;
      @(negedge clock);
      request = 1'b0;
      rand_in = AW'($urandom);
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (mid_req && cyc == 1) begin
            request  = 1'b1;
            grid_max = AW'(mid_gmax);
         end
         if (mid_req && cyc == 2) request = 1'b0;
         if (cyc == 1) obs_b1 = busy;
         if (cyc == 2) obs_b2 = busy;
         if (busy && (cyc % 2 == 1)) obs_addr.push_back(int'(occ_addr));
         if (done || full) begin
            obs_cycle = cyc;
            obs_done  = done;
            obs_full  = full;
            obs_both  = done && full;
            break;
         end
         @(negedge clock);
      end
      request = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; request = 1'b0; grid_max = AW'(99); rand_in = '0;
      #1;
      n_cmp++;
      if ({done, full, busy} !== 3'b000) begin
         n_bad++; $display("FAIL reset_flags: got %b want 000", {done, full, busy});
      end
      n_cmp++;
      if (food_pos !== '0 || occ_addr !== '0) begin
         n_bad++; $display("FAIL reset_regs: food_pos %0d occ_addr %0d want 0 0", food_pos, occ_addr);
      end
      n_cmp++;
      if (rand_max !== AW'(99)) begin
         n_bad++; $display("FAIL rand_max: got %0d want 99", rand_max);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      clear_mem();
      @(negedge clock);
      do_request(42, 99, 0, 0);
      n_cmp++;
      if ({obs_b1, obs_b2} !== 2'b11) begin
         n_bad++; $display("FAIL basic_busy: got %b want 11", {obs_b1, obs_b2});
      end
      n_cmp++;
      if (obs_cycle != 3 || !obs_done || obs_full) begin
         n_bad++; $display("FAIL basic_done: cycle %0d done %0d full %0d want 3 1 0", obs_cycle, obs_done, obs_full);
      end
      n_cmp++;
      if (food_pos !== AW'(42)) begin
         n_bad++; $display("FAIL basic_pos: got %0d want 42", food_pos);
      end
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL basic_pulse: done %b busy %b want 0 0", done, busy);
      end
   endtask

   task automatic test_wrap();
      int exp_seq [5] = '{98, 99, 0, 1, 2};
      clear_mem();
      mem[98] = 1; mem[99] = 1; mem[0] = 1; mem[1] = 1;
      @(negedge clock);
      do_request(98, 99, 0, 0);
      n_cmp++;
      if (obs_addr.size() != 5) begin
         n_bad++; $display("FAIL wrap_nprobe: got %0d want 5", obs_addr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs_addr[i] != exp_seq[i]) begin
               n_bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, obs_addr[i], exp_seq[i]);
            end
         end
      end
      n_cmp++;
      if (obs_cycle != 11 || !obs_done || food_pos !== AW'(2)) begin
         n_bad++; $display("FAIL wrap_done: cycle %0d done %0d pos %0d want 11 1 2", obs_cycle, obs_done, food_pos);
      end
   endtask

   task automatic test_full();
      int exp_seq [4] = '{1, 2, 3, 0};
      logic [AW-1:0] prev;
      clear_mem();
      for (int i = 0; i < 4; i++) mem[i] = 1;
      prev = food_pos;
      @(negedge clock);
      do_request(1, 3, 0, 0);
      n_cmp++;
      if (obs_addr.size() != 4) begin
         n_bad++; $display("FAIL full_nprobe: got %0d want 4", obs_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_addr[i] != exp_seq[i]) begin
               n_bad++; $display("FAIL full_addr%0d: got %0d want %0d", i, obs_addr[i], exp_seq[i]);
            end
         end
      end
      n_cmp++;
      if (obs_cycle != 9 || !obs_full || obs_done) begin
         n_bad++; $display("FAIL full_flag: cycle %0d full %0d done %0d want 9 1 0", obs_cycle, obs_full, obs_done);
      end
      n_cmp++;
      if (food_pos !== prev) begin
         n_bad++; $display("FAIL full_pos: got %0d want %0d", food_pos, prev);
      end
   endtask

   task automatic test_out_of_range();
      clear_mem();
      mem[5] = 1;
      @(negedge clock);
      do_request(120, 99, 0, 0);
      n_cmp++;
      if (obs_cycle != 3 || food_pos !== '0) begin
         n_bad++; $display("FAIL oor: cycle %0d pos %0d want 3 0", obs_cycle, food_pos);
      end
   endtask

   task automatic test_ignore_busy();
      clear_mem();
      @(negedge clock);
      do_request(42, 99, 1, 10);
      n_cmp++;
      if (obs_cycle != 3 || !obs_done || food_pos !== AW'(42)) begin
         n_bad++; $display("FAIL ignore: cycle %0d done %0d pos %0d want 3 1 42", obs_cycle, obs_done, food_pos);
      end
      n_cmp++;
      if (obs_addr.size() != 1 || obs_addr[0] != 42) begin
         n_bad++; $display("FAIL ignore_probe: nprobe %0d want 1 at 42", obs_addr.size());
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      clear_mem();
      @(negedge clock);
      do_request(7, 99, 0, 0);
      request = 1'b1; rand_in = AW'(20); grid_max = AW'(99);
      @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL b2b_same: busy %b want 0", busy);
      end
      request = 1'b1; rand_in = AW'(30);
      @(negedge clock);
      request = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++; $display("FAIL b2b_next: busy %b want 1", busy);
      end
      cnt = 0;
      while (!done && cnt < 10) begin
         @(negedge clock);
         cnt++;
      end
      n_cmp++;
      if (done !== 1'b1 || food_pos !== AW'(30)) begin
         n_bad++; $display("FAIL b2b_pos: done %b pos %0d want 1 30", done, food_pos);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      clear_mem();
      @(negedge clock);
      request = 1'b1; rand_in = AW'(55); grid_max = AW'(99);
      @(negedge clock);
      request = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({done, full, busy} !== 3'b000 || food_pos !== '0 || occ_addr !== '0) begin
         n_bad++; $display("FAIL rst_async: dfb %b pos %0d addr %0d want 000 0 0", {done, full, busy}, food_pos, occ_addr);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (done || full) pulses++;
      end
      reset = 1'b0;
      @(negedge clock);
      if (done || full) pulses++;
      n_cmp++;
      if (pulses != 0) begin
         n_bad++; $display("FAIL rst_nopulse: got %0d pulses want 0", pulses);
      end
      do_request(55, 99, 0, 0);
      n_cmp++;
      if (obs_cycle != 3 || food_pos !== AW'(55)) begin
         n_bad++; $display("FAIL rst_after: cycle %0d pos %0d want 3 55", obs_cycle, food_pos);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int gmax, start, s, exp_k, exp_pos, exp_cycle, bad_addr;
         bit exp_full;
         logic [AW-1:0] prev;
         gmax = $urandom_range(0, 40);
         clear_mem();
         for (int i = 0; i <= gmax; i++) mem[i] = ($urandom_range(0, 99) < 60);
         if (it % 5 == 4) for (int i = 0; i <= gmax; i++) mem[i] = 1;
         start = $urandom_range(0, gmax + 20);
         s = (start > gmax) ? 0 : start;
         exp_full = 1; exp_k = gmax; exp_pos = 0;
         for (int k = 0; k <= gmax; k++) begin
            if (!mem[(s + k) % (gmax + 1)]) begin
               exp_full = 0; exp_k = k; exp_pos = (s + k) % (gmax + 1);
               break;
            end
         end
         exp_cycle = 3 + 2 * exp_k;
         prev = food_pos;
         @(negedge clock);
         do_request(start, gmax, 0, 0);
         n_cmp++;
         if (obs_cycle != exp_cycle || obs_full != exp_full || obs_done != !exp_full || obs_both) begin
            n_bad++;
            $display("FAIL rnd%0d_flags: cycle %0d done %0d full %0d want %0d %0d %0d", it, obs_cycle, obs_done, obs_full, exp_cycle, !exp_full, exp_full);
         end
         n_cmp++;
         if (food_pos !== (exp_full ? prev : AW'(exp_pos))) begin
            n_bad++; $display("FAIL rnd%0d_pos: got %0d want %0d", it, food_pos, exp_full ? int'(prev) : exp_pos);
         end
         bad_addr = (obs_addr.size() != exp_k + 1) ? 1 : 0;
         if (!bad_addr)
            for (int k = 0; k <= exp_k; k++)
               if (obs_addr[k] != (s + k) % (gmax + 1)) bad_addr++;
         n_cmp++;
         if (bad_addr != 0) begin
            n_bad++; $display("FAIL rnd%0d_probes: got %0d probes want %0d", it, obs_addr.size(), exp_k + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_full();
      test_out_of_range();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
